// File: rtl/fsm_table_engine.sv
// Run-time programmable Moore FSM. A {state, symbol}-indexed table supplies next state and output.
// Optional step counter (step_cnt port) is built when FSM_TRACE_EN is defined.
module fsm_table_engine #(
    parameter int STATE_W     = 3,
    parameter int IN_W        = 2,
    parameter int OUT_W       = 3,
    parameter int RESET_STATE = 0,
    parameter int CNT_W       = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic [IN_W-1:0]          a,
    input  logic                     cfg_we,
    input  logic [STATE_W+IN_W-1:0]  cfg_addr,
    input  logic [OUT_W+STATE_W-1:0] cfg_data,
    input  logic                     err_clr,
    output logic [STATE_W-1:0]       state,
    output logic [OUT_W-1:0]         saida,
`ifdef FSM_TRACE_EN
    output logic [CNT_W-1:0]         step_cnt,
`endif
    output logic                     err
);

    localparam int ADDR_W = STATE_W + IN_W;
    localparam int ENT_W  = OUT_W + STATE_W;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam logic [STATE_W-1:0] RST_STATE = RESET_STATE[STATE_W-1:0];

    // Run/error mode; err is a direct decode of this state.
    typedef enum logic {
        MODE_RUN = 1'b0,
        MODE_ERR = 1'b1
    } mode_t;

    mode_t              mode, mode_next;
    logic [ENT_W-1:0]   table_mem [DEPTH];
    logic [DEPTH-1:0]   valid;

    logic [ADDR_W-1:0]  rd_idx;
    logic [ENT_W-1:0]   entry;
    logic               entry_valid;
    logic [STATE_W-1:0] state_next;
    logic [OUT_W-1:0]   saida_next;
    logic               step_ok;

    // Nonblocking table/valid updates give read-before-write for a same-index write.
    assign rd_idx      = {state, a};
    assign entry       = table_mem[rd_idx];
    assign entry_valid = valid[rd_idx];
    assign err         = (mode == MODE_ERR);

    always_comb begin
        mode_next  = mode;
        state_next = state;
        saida_next = saida;
        step_ok    = 1'b0;
        if (err_clr) begin
            mode_next = MODE_RUN;
        end else if (en && mode == MODE_RUN) begin
            if (entry_valid) begin
                state_next = entry[STATE_W-1:0];
                saida_next = entry[ENT_W-1:STATE_W];
                step_ok    = 1'b1;
            end else begin
                mode_next = MODE_ERR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode  <= MODE_RUN;
            state <= RST_STATE;
            saida <= '0;
            valid <= '0;
        end else begin
            mode  <= mode_next;
            state <= state_next;
            saida <= saida_next;
            if (cfg_we) begin
                valid[cfg_addr] <= 1'b1;
            end
        end
    end

    // Table data is deliberately not reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        if (!reset && cfg_we) begin
            table_mem[cfg_addr] <= cfg_data;
        end
    end

`ifdef FSM_TRACE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            step_cnt <= '0;
        end else if (step_ok) begin
            step_cnt <= step_cnt + 1'b1;
        end
    end
`else
    localparam int UNUSED_CNT_W = CNT_W;
    logic unused_step_ok;
    assign unused_step_ok = step_ok;
`endif

endmodule
